// File: rtl/goertzel_bin_scheduler.sv
// goertzel_bin_scheduler
//   Time-shares one single-bin Goertzel engine across NB tone bins. A frame of
//   NS samples is captured into an internal buffer. For each bin the engine is
//   then held in reset, given that bin's coefficients, fed the whole frame
//   back without bubbles, and its power result is collected (or flagged as
//   timed out). One result pulse is emitted per bin, then a done pulse.
//
//   Optional build macro: GOERTZEL_THRESH_EN adds thresh_i / det_mask_o, which
//   give a per-frame mask of bins whose power exceeded thresh_i.
//
// Ports
//   clk_i, rstn_i                  clock, async active-low reset
//   cfg_we_i/bin_i/sel_i/wdata_i   coefficient bank write (sel 0=alpha,1=cW_re,2=cW_im)
//   start_i, busy_o                frame start (IDLE only), activity flag
//   samp_valid_i/ready_o/data_i    sample capture handshake
//   eng_rstn_o, eng_en_o, eng_data_o          engine control and replayed sample
//   eng_alpha_o, eng_cw_re_o, eng_cw_im_o     current bin's coefficients
//   eng_valid_i, eng_result_i      engine result (valid is sticky until engine reset)
//   res_valid_o/bin_o/data_o/tmo_o per-bin result pulse
//   done_o                         one-cycle pulse after the last bin
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | waiting for start_i, engine held in reset
// CAPTURE  | accepting NS samples into the frame buffer
// ENG_RST  | engine reset low for RST_CYC cycles, coefficients latched on entry
// FEED     | replaying the frame into the engine, NS consecutive cycles
// WAIT     | waiting for eng_valid_i, at most TMO cycles
// OUT      | presenting the bin result for one cycle
// DONE     | frame-done pulse
module goertzel_bin_scheduler #(
   parameter int NS      = 1000,
   parameter int NB      = 8,
   parameter int RST_CYC = 2,
   parameter int TMO     = 64,
   localparam int BW     = (NB > 1) ? $clog2(NB) : 1
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          cfg_we_i,
   input  logic [BW-1:0] cfg_bin_i,
   input  logic [1:0]    cfg_sel_i,
   input  logic [63:0]   cfg_wdata_i,
   input  logic          start_i,
   output logic          busy_o,
   input  logic          samp_valid_i,
   output logic          samp_ready_o,
   input  logic [31:0]   samp_data_i,
   output logic          eng_rstn_o,
   output logic          eng_en_o,
   output logic [63:0]   eng_alpha_o,
   output logic [63:0]   eng_cw_re_o,
   output logic [63:0]   eng_cw_im_o,
   output logic [31:0]   eng_data_o,
   input  logic          eng_valid_i,
   input  logic [31:0]   eng_result_i,
   output logic          res_valid_o,
   output logic [BW-1:0] res_bin_o,
   output logic [31:0]   res_data_o,
   output logic          res_tmo_o,
`ifdef GOERTZEL_THRESH_EN
   input  logic [31:0]   thresh_i,
   output logic [NB-1:0] det_mask_o,
`endif
   output logic          done_o
);

   localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
   localparam int RW  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam int TW  = (TMO > 1) ? $clog2(TMO) : 1;
   localparam int BW1 = BW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_ENG_RST, S_FEED, S_WAIT, S_OUT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] sidx_q, sidx_d;
   logic [SW-1:0] ridx_q, ridx_d;
   logic [BW-1:0] bin_q, bin_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [31:0]   res_data_q, res_data_d;
   logic          res_tmo_q, res_tmo_d;

   logic [31:0]   smp_buf_q [NS];
   logic [63:0]   alpha_q [NB];
   logic [63:0]   cwre_q  [NB];
   logic [63:0]   cwim_q  [NB];
   logic [63:0]   eng_alpha_q, eng_cw_re_q, eng_cw_im_q;

   logic          cfg_ok;
   logic          coef_load;

   assign cfg_ok    = ({1'b0, cfg_bin_i} < BW1'(NB)) && (cfg_sel_i != 2'd3);
   // Coefficients are snapshotted when a bin's run begins, so a bank write
   // to the running bin only shows up on its next run.
   assign coef_load = (state_d == S_ENG_RST) && (state_q != S_ENG_RST);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         sidx_q     <= '0;
         ridx_q     <= '0;
         bin_q      <= '0;
         rcnt_q     <= '0;
         tcnt_q     <= '0;
         res_data_q <= '0;
         res_tmo_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sidx_q     <= sidx_d;
         ridx_q     <= ridx_d;
         bin_q      <= bin_d;
         rcnt_q     <= rcnt_d;
         tcnt_q     <= tcnt_d;
         res_data_q <= res_data_d;
         res_tmo_q  <= res_tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sidx_d     = sidx_q;
      ridx_d     = ridx_q;
      bin_d      = bin_q;
      rcnt_d     = rcnt_q;
      tcnt_d     = tcnt_q;
      res_data_d = res_data_q;
      res_tmo_d  = res_tmo_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_CAPTURE;
               sidx_d  = '0;
            end
         end
         S_CAPTURE: begin
            if (samp_valid_i) begin
               if (sidx_q == SW'(NS - 1)) begin
                  state_d = S_ENG_RST;
                  sidx_d  = '0;
                  bin_d   = '0;
                  rcnt_d  = RW'(RST_CYC - 1);
               end else begin
                  sidx_d = sidx_q + 1'b1;
               end
            end
         end
         S_ENG_RST: begin
            if (rcnt_q == '0) begin
               state_d = S_FEED;
               ridx_d  = '0;
            end else begin
               rcnt_d = rcnt_q - 1'b1;
            end
         end
         S_FEED: begin
            if (ridx_q == SW'(NS - 1)) begin
               state_d = S_WAIT;
               tcnt_d  = TW'(TMO - 1);
            end else begin
               ridx_d = ridx_q + 1'b1;
            end
         end
         S_WAIT: begin
            // A result arriving on the last allowed cycle still wins.
            if (eng_valid_i) begin
               state_d    = S_OUT;
               res_data_d = eng_result_i;
               res_tmo_d  = 1'b0;
            end else if (tcnt_q == '0) begin
               state_d    = S_OUT;
               res_data_d = '0;
               res_tmo_d  = 1'b1;
            end else begin
               tcnt_d = tcnt_q - 1'b1;
            end
         end
         S_OUT: begin
            if (bin_q == BW'(NB - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_ENG_RST;
               bin_d   = bin_q + 1'b1;
               rcnt_d  = RW'(RST_CYC - 1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o       = (state_q != S_IDLE);
      samp_ready_o = (state_q == S_CAPTURE);
      eng_rstn_o   = (state_q == S_FEED) || (state_q == S_WAIT) || (state_q == S_OUT);
      eng_en_o     = (state_q == S_FEED);
      eng_data_o   = (state_q == S_FEED) ? smp_buf_q[ridx_q] : '0;
      eng_alpha_o  = eng_alpha_q;
      eng_cw_re_o  = eng_cw_re_q;
      eng_cw_im_o  = eng_cw_im_q;
      res_valid_o  = (state_q == S_OUT);
      res_bin_o    = bin_q;
      res_data_o   = res_data_q;
      res_tmo_o    = res_tmo_q;
      done_o       = (state_q == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if ((state_q == S_CAPTURE) && samp_valid_i) begin
         smp_buf_q[sidx_q] <= samp_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NB; i++) begin
            alpha_q[i] <= '0;
            cwre_q[i]  <= '0;
            cwim_q[i]  <= '0;
         end
         eng_alpha_q <= '0;
         eng_cw_re_q <= '0;
         eng_cw_im_q <= '0;
      end else begin
         if (cfg_we_i && cfg_ok) begin
            case (cfg_sel_i)
               2'd0:    alpha_q[cfg_bin_i] <= cfg_wdata_i;
               2'd1:    cwre_q[cfg_bin_i]  <= cfg_wdata_i;
               2'd2:    cwim_q[cfg_bin_i]  <= cfg_wdata_i;
               default: ;
            endcase
         end
         if (coef_load) begin
            eng_alpha_q <= alpha_q[bin_d];
            eng_cw_re_q <= cwre_q[bin_d];
            eng_cw_im_q <= cwim_q[bin_d];
         end
      end
   end

`ifdef GOERTZEL_THRESH_EN
   logic [NB-1:0] acc_q;
   logic [NB-1:0] det_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc_q <= '0;
         det_q <= '0;
      end else begin
         if ((state_q == S_IDLE) && start_i) begin
            acc_q <= '0;
         end else if ((state_q == S_OUT) && !res_tmo_q && (res_data_q > thresh_i)) begin
            acc_q[bin_q] <= 1'b1;
         end
         if (state_q == S_DONE) begin
            det_q <= acc_q;
         end
      end
   end

   assign det_mask_o = det_q;
`endif

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
module tb_goertzel_bin_scheduler;
   localparam int NS      = 16;
   localparam int NB      = 2;
   localparam int RST_CYC = 2;
   localparam int TMO     = 64;
   localparam int WNOM    = 5;
   localparam int THRESH  = 50;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn = 1'b0;
   logic        cfg_we = 1'b0;
   logic [0:0]  cfg_bin = '0;
   logic [1:0]  cfg_sel = '0;
   logic [63:0] cfg_wdata = '0;
   logic        start = 1'b0;
   logic        busy;
   logic        samp_valid = 1'b0;
   logic        samp_ready;
   logic [31:0] samp_data = '0;
   logic        eng_rstn, eng_en;
   logic [63:0] eng_alpha, eng_cw_re, eng_cw_im;
   logic [31:0] eng_data;
   logic        eng_valid = 1'b0;
   logic [31:0] eng_result = '0;
   logic        res_valid;
   logic [0:0]  res_bin;
   logic [31:0] res_data;
   logic        res_tmo, done;
`ifdef GOERTZEL_THRESH_EN
   logic [31:0]   thresh = THRESH;
   logic [NB-1:0] det_mask;
`endif

   goertzel_bin_scheduler #(.NS(NS), .NB(NB), .RST_CYC(RST_CYC), .TMO(TMO)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .cfg_we_i(cfg_we), .cfg_bin_i(cfg_bin), .cfg_sel_i(cfg_sel), .cfg_wdata_i(cfg_wdata),
      .start_i(start), .busy_o(busy),
      .samp_valid_i(samp_valid), .samp_ready_o(samp_ready), .samp_data_i(samp_data),
      .eng_rstn_o(eng_rstn), .eng_en_o(eng_en),
      .eng_alpha_o(eng_alpha), .eng_cw_re_o(eng_cw_re), .eng_cw_im_o(eng_cw_im),
      .eng_data_o(eng_data), .eng_valid_i(eng_valid), .eng_result_i(eng_result),
      .res_valid_o(res_valid), .res_bin_o(res_bin), .res_data_o(res_data), .res_tmo_o(res_tmo),
`ifdef GOERTZEL_THRESH_EN
      .thresh_i(thresh), .det_mask_o(det_mask),
`endif
      .done_o(done)
   );

   logic [63:0] K_ALPHA [NB] = '{64'hA0A0_0000_0000_1000, 64'hA1A1_0000_0000_2000};
   logic [63:0] K_RE    [NB] = '{64'hB0B0_0000_0000_0011, 64'hB1B1_0000_0000_0022};
   logic [63:0] K_IM    [NB] = '{64'hC0C0_0000_0000_0033, 64'hC1C1_0000_0000_0044};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int silent  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Engine stand-in: counts enabled samples since its reset, then raises a
   // sticky valid WNOM cycles into the wait; result identifies the bin by alpha.
   int e_cnt = 0;
   int e_w   = 0;
   always @(negedge clk) begin
      if (!eng_rstn) begin
         e_cnt = 0; e_w = 0; eng_valid = 1'b0; eng_result = '0;
      end else if (eng_en) begin
         e_cnt++;
      end else if (e_cnt == NS) begin
         if (e_w == WNOM - 1 && silent == 0) begin
            eng_valid  = 1'b1;
            eng_result = (eng_alpha == K_ALPHA[1]) ? 32'd107 : 32'd7;
         end
         e_w++;
      end
   end

   // Model state: bank contents, captured frame, frame phase.
   logic [63:0]   m_alpha [NB];
   logic [63:0]   m_re    [NB];
   logic [63:0]   m_im    [NB];
   logic [31:0]   cap     [NS];
   logic [NB-1:0] fmask = '0;
   logic [NB-1:0] exp_det = '0;
   int phase = 0, ncap = 0, c0 = 0;

   // Observations of the DUT used for hand-computed literal checks.
   logic [33:0] act_q [$];
   int hs_cnt = 0, hs_cyc = 0, done_cnt = 0, done_cyc = 0;

   always @(negedge clk) begin
      int off, b, k, w, p, er;
      if (samp_valid && samp_ready) begin hs_cnt++; hs_cyc = cyc; end
      if (res_valid) act_q.push_back({res_bin, res_tmo, res_data});
      if (done) begin done_cnt++; done_cyc = cyc; end

      if (!rstn) begin
         phase = 0; exp_det = '0;
         for (int i = 0; i < NB; i++) begin m_alpha[i] = '0; m_re[i] = '0; m_im[i] = '0; end
      end
`ifdef GOERTZEL_THRESH_EN
      chk("det_mask", det_mask, exp_det);
`endif
      if (!rstn || phase == 0) begin
         chk("idle_busy", busy, 0);
         chk("idle_ready", samp_ready, 0);
         chk("idle_eng_rstn", eng_rstn, 0);
         chk("idle_eng_en", eng_en, 0);
         chk("idle_eng_data", eng_data, 0);
         chk("idle_res_valid", res_valid, 0);
         chk("idle_done", done, 0);
         if (!rstn) begin
            chk("rst_alpha", eng_alpha, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_res_tmo", res_tmo, 0);
         end else if (start) begin
            phase = 1; ncap = 0;
         end
      end else if (phase == 1) begin
         chk("cap_busy", busy, 1);
         chk("cap_ready", samp_ready, 1);
         chk("cap_eng_rstn", eng_rstn, 0);
         chk("cap_eng_en", eng_en, 0);
         chk("cap_res_valid", res_valid, 0);
         chk("cap_done", done, 0);
         if (samp_valid) begin
            cap[ncap] = samp_data;
            ncap++;
            if (ncap == NS) begin phase = 2; c0 = cyc; fmask = '0; end
         end
      end else begin
         w   = (silent != 0) ? TMO : WNOM;
         p   = RST_CYC + NS + w + 1;
         off = cyc - c0 - 1;
         chk("run_busy", busy, 1);
         chk("run_ready", samp_ready, 0);
         if (off < NB * p) begin
            b = off / p;
            k = off % p;
            chk("run_eng_rstn", eng_rstn, k >= RST_CYC);
            chk("run_eng_en", eng_en, (k >= RST_CYC) && (k < RST_CYC + NS));
            chk("run_eng_data", eng_data,
                ((k >= RST_CYC) && (k < RST_CYC + NS)) ? cap[k - RST_CYC] : 32'd0);
            chk("run_alpha", eng_alpha, m_alpha[b]);
            chk("run_cw_re", eng_cw_re, m_re[b]);
            chk("run_cw_im", eng_cw_im, m_im[b]);
            chk("run_res_valid", res_valid, k == p - 1);
            chk("run_done", done, 0);
            if (k == p - 1) begin
               er = (silent != 0) ? 0 : b * 100 + 7;
               chk("res_bin", res_bin, b);
               chk("res_data", res_data, er);
               chk("res_tmo", res_tmo, silent != 0);
               if (silent == 0 && er > THRESH) fmask[b] = 1'b1;
            end
         end else begin
            chk("end_done", done, 1);
            chk("end_eng_en", eng_en, 0);
            chk("end_res_valid", res_valid, 0);
            phase   = 0;
            exp_det = fmask;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cfg_write(input int b, input int s, input logic [63:0] v);
      cfg_we = 1'b1; cfg_bin = b[0:0]; cfg_sel = s[1:0]; cfg_wdata = v;
      if (s == 0) m_alpha[b] = v;
      else if (s == 1) m_re[b] = v;
      else if (s == 2) m_im[b] = v;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic load_cfg();
      for (int b = 0; b < NB; b++) begin
         cfg_write(b, 0, K_ALPHA[b]);
         cfg_write(b, 1, K_RE[b]);
         cfg_write(b, 2, K_IM[b]);
      end
      cfg_write(0, 3, 64'hFFFF_FFFF_FFFF_FFFF);
      cfg_write(1, 3, 64'h1234_5678_9ABC_DEF0);
   endtask

   task automatic feed_frame(input int base, input int gap);
      act_q.delete();
      hs_cnt = 0;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < NS; i++) begin
         for (int g = 0; g < gap; g++) tick();
         samp_valid = 1'b1; samp_data = base + i; tick();
         samp_valid = 1'b0; samp_data = '0;
      end
   endtask

   task automatic wait_done(input string nm, input int d0, input int lim);
      int n = 0;
      while (done_cnt == d0 && n < lim) begin @(posedge clk); n++; end
      #1;
      chk(nm, done_cnt != d0, 1);
   endtask

   function automatic logic [33:0] res_at(input int i);
      return (i < act_q.size()) ? act_q[i] : 34'h3_FFFF_FFFF;
   endfunction

   task automatic wait_bin_feed(input int b);
      int n = 0;
      while (!(eng_en && eng_alpha == K_ALPHA[b]) && n < 200) begin tick(); n++; end
      chk("reach_feed", eng_en, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      repeat (3) tick();
      chk("rst_eng_rstn_lit", eng_rstn, 0);
      chk("rst_busy_lit", busy, 0);
      rstn = 1'b1;
      tick();
      load_cfg();
      // samples offered while idle must not be captured
      samp_valid = 1'b1; samp_data = 32'hDEAD_BEEF; tick(); tick();
      samp_valid = 1'b0;

      // frame 1: contiguous samples 1..16
      d0 = done_cnt;
      feed_frame(1, 0);
      wait_done("f1_done", d0, 400);
      chk("f1_handshakes", hs_cnt, 16);
      chk("f1_latency", done_cyc - hs_cyc, 49);
      chk("f1_nres", act_q.size(), 2);
      chk("f1_res0", res_at(0), {1'b0, 1'b0, 32'd7});
      chk("f1_res1", res_at(1), {1'b1, 1'b0, 32'd107});
      repeat (3) tick();
      chk("f1_busy_low", busy, 0);
`ifdef GOERTZEL_THRESH_EN
      chk("f1_det_mask", det_mask, 2'b10);
`endif

      // frame 2: samp_valid every third cycle
      d0 = done_cnt;
      feed_frame(201, 2);
      wait_done("f2_done", d0, 400);
      chk("f2_handshakes", hs_cnt, 16);
      chk("f2_latency", done_cyc - hs_cyc, 49);
      chk("f2_res1", res_at(1), {1'b1, 1'b0, 32'd107});
      repeat (3) tick();

      // frame 3: engine never answers
      silent = 1;
      d0 = done_cnt;
      feed_frame(301, 0);
      wait_done("f3_done", d0, 400);
      chk("f3_latency", done_cyc - hs_cyc, 167);
      chk("f3_res0", res_at(0), {1'b0, 1'b1, 32'd0});
      chk("f3_res1", res_at(1), {1'b1, 1'b1, 32'd0});
      repeat (3) tick();
`ifdef GOERTZEL_THRESH_EN
      chk("f3_det_mask", det_mask, 2'b00);
`endif
      silent = 0;
      repeat (2) tick();

      // frame 4: start pulsed during FEED is ignored
      d0 = done_cnt;
      feed_frame(401, 0);
      wait_bin_feed(0);
      repeat (3) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_done("f4_done", d0, 400);
      repeat (80) tick();
      chk("f4_one_done", done_cnt - d0, 1);
      chk("f4_res0", res_at(0), {1'b0, 1'b0, 32'd7});
      chk("f4_busy_low", busy, 0);

      // frame 5: reset during bin 1 FEED aborts the frame
      d0 = done_cnt;
      feed_frame(501, 0);
      wait_bin_feed(1);
      repeat (4) tick();
      rstn = 1'b0;
      @(negedge clk);
      chk("f5_rst_eng_rstn", eng_rstn, 0);
      chk("f5_rst_busy", busy, 0);
      chk("f5_rst_en", eng_en, 0);
      tick(); tick();
      rstn = 1'b1;
      repeat (150) tick();
      chk("f5_no_done", done_cnt - d0, 0);
      chk("f5_nres", act_q.size(), 1);
      chk("f5_alpha_cleared", eng_alpha, 0);
`ifdef GOERTZEL_THRESH_EN
      chk("f5_det_cleared", det_mask, 2'b00);
`endif

      // frame 6: clean frame after reset
      load_cfg();
      d0 = done_cnt;
      feed_frame(601, 0);
      wait_done("f6_done", d0, 400);
      chk("f6_latency", done_cyc - hs_cyc, 49);
      chk("f6_res0", res_at(0), {1'b0, 1'b0, 32'd7});
      chk("f6_res1", res_at(1), {1'b1, 1'b0, 32'd107});
      repeat (3) tick();
`ifdef GOERTZEL_THRESH_EN
      chk("f6_det_mask", det_mask, 2'b10);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
